// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU sequential multiplier.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  localparam int MUL_WIDTH = 8;
  localparam int MUL_CNT_W = 3;
  localparam int MUL_ITERS = 8;

endpackage

// File: rtl/mul_datapath.sv
// Multiplier datapath: M/ACC/Q registers, ripple-carry adder and right shifter.
// SEQ_MUL_SIGNED_EN selects radix-2 Booth (signed) instead of unsigned shift-add.
module mul_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 latch,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [2*WIDTH-1:0] product_q, product_d;
`ifdef SEQ_MUL_SIGNED_EN
  logic               qm1_q, qm1_d;
`endif

  // One bit wider than ACC: holds the carry (unsigned) or the true sign (Booth)
  logic [WIDTH:0]     acc_x;
  logic [WIDTH:0]     addend;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_shift;
  logic [WIDTH-1:0]   q_shift;

  always_comb begin
    addend = '0;
    cin    = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
    acc_x = {acc_q[WIDTH-1], acc_q};
    case ({q_q[0], qm1_q})
      2'b01:   addend = {m_q[WIDTH-1], m_q};
      2'b10: begin
        addend = ~{m_q[WIDTH-1], m_q};
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
`else
    acc_x = {1'b0, acc_q};
    if (q_q[0]) addend = {1'b0, m_q};
`endif
  end

  always_comb begin
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i <= WIDTH; i++) begin
      sum[i] = acc_x[i] ^ addend[i] ^ c;
      c      = (acc_x[i] & addend[i]) | (c & (acc_x[i] ^ addend[i]));
    end
    acc_shift = sum[WIDTH:1];
    q_shift   = {sum[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    product_d = product_q;
`ifdef SEQ_MUL_SIGNED_EN
    qm1_d     = qm1_q;
`endif
    if (load) begin
      m_d   = a_in;
      q_d   = b_in;
      acc_d = '0;
`ifdef SEQ_MUL_SIGNED_EN
      qm1_d = 1'b0;
`endif
    end else if (step) begin
      acc_d = acc_shift;
      q_d   = q_shift;
`ifdef SEQ_MUL_SIGNED_EN
      qm1_d = q_q[0];
`endif
    end
    if (latch) product_d = {acc_shift, q_shift};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      product_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      qm1_q     <= 1'b0;
`endif
    end else begin
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      product_q <= product_d;
`ifdef SEQ_MUL_SIGNED_EN
      qm1_q     <= qm1_d;
`endif
    end
  end

  assign product = product_q;

endmodule

// File: rtl/seq_mul_ctrl.sv
// Sequential multiplier controller: start/ready handshake, drives the external
// 3-bit iteration counter. Optional signed Booth mode via SEQ_MUL_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// LOAD  | clear iteration counter, one cycle
// ITER  | one add/shift per clock until counter reports done
// DONE  | ready pulse, product valid
module seq_mul_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [CNT_W-1:0]     iter_count,
  input  logic                 iter_done,
  output logic                 cnt_en,
  output logic                 cnt_clr,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   product
);

  mul_state_e state_q, state_d;
  logic       load, step, latch;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = ITER;
      ITER: begin
        step = 1'b1;
        if (iter_done) begin
          latch   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter saturates at 7, so it must be cleared in LOAD and held clear during reset
  assign cnt_clr = (state_q == LOAD) | RST;
  assign cnt_en  = (state_q == ITER);
  assign busy    = (state_q == LOAD) | (state_q == ITER);
  assign ready   = (state_q == DONE);

  mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (CLK),
    .rst     (RST),
    .load    (load),
    .step    (step),
    .latch   (latch),
    .a_in    (a_in),
    .b_in    (b_in),
    .product (product)
  );

  a_done_at_last_count : assert property (@(posedge CLK) disable iff (RST)
    (state_q == ITER && iter_done) |-> (iter_count == CNT_W'(MUL_ITERS - 1)));

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Directed bench for seq_mul_ctrl with a behavioural saturating 3-bit iteration counter.
module tb_seq_mul_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic [2:0]  cnt = '0;
  logic        iter_done;
  logic        cnt_en, cnt_clr, busy, ready;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK) begin
    if (cnt_clr || RST)              cnt <= 3'd0;
    else if (cnt_en && cnt != 3'd7)  cnt <= cnt + 3'd1;
  end
  assign iter_done = (cnt == 3'd7);

  seq_mul_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .iter_count (cnt),
    .iter_done  (iter_done),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .busy       (busy),
    .ready      (ready),
    .product    (product)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ready !== 1'b0)    begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (cnt_en !== 1'b0)   begin errors++; $display("FAIL reset_cnt_en got %b want 0", cnt_en); end
    checks++; if (cnt_clr !== 1'b1)  begin errors++; $display("FAIL reset_cnt_clr got %b want 1", cnt_clr); end
    checks++; if (product !== 16'h0) begin errors++; $display("FAIL reset_product got %h want 0000", product); end
    RST = 1'b0;
    tick();
    checks++; if (cnt_clr !== 1'b0)  begin errors++; $display("FAIL idle_cnt_clr got %b want 0", cnt_clr); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_mul(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string name);
    int lat;
    int bcnt;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    lat  = 0;
    bcnt = 0;
    while (ready !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
    checks++; if (lat != 9)        begin errors++; $display("FAIL %s latency got %0d want 9", name, lat); end
    checks++; if (bcnt != 9)       begin errors++; $display("FAIL %s busy_cycles got %0d want 9", name, bcnt); end
    checks++; if (product !== exp) begin errors++; $display("FAIL %s product got %h want %h", name, product, exp); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL %s busy_at_ready got %b want 0", name, busy); end
    tick();
    checks++; if (ready !== 1'b0)  begin errors++; $display("FAIL %s ready_pulse got %b want 0", name, ready); end
    repeat (3) tick();
    checks++; if (product !== exp) begin errors++; $display("FAIL %s product_hold got %h want %h", name, product, exp); end
  endtask

  task automatic test_start_ignored();
    int pulses;
    logic [15:0] seen;
    pulses = 0;
    seen   = '0;
    a_in = 8'd13; b_in = 8'd11; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ready === 1'b1) begin
        pulses++;
        seen = product;
      end
    end
    checks++; if (pulses != 1)      begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    checks++; if (seen !== 16'h008F) begin errors++; $display("FAIL ignore_product got %h want 008f", seen); end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    pulses = 0;
    a_in = 8'd13; b_in = 8'd11; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++; if (cnt_en !== 1'b1)  begin errors++; $display("FAIL midrst_in_iter got %b want 1", cnt_en); end
    RST = 1'b1;
    tick();
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (ready !== 1'b0)    begin errors++; $display("FAIL midrst_ready got %b want 0", ready); end
    checks++; if (product !== 16'h0) begin errors++; $display("FAIL midrst_product got %h want 0000", product); end
    checks++; if (cnt_en !== 1'b0)   begin errors++; $display("FAIL midrst_cnt_en got %b want 0", cnt_en); end
    RST = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ready === 1'b1) pulses++;
    end
    checks++; if (pulses != 0)       begin errors++; $display("FAIL midrst_no_ready got %0d want 0", pulses); end
    test_mul(8'd6, 8'd7, 16'h002A, "after_reset_6x7");
  endtask

  task automatic test_back_to_back();
    logic exp_ready;
    a_in = 8'd3;
    b_in = 8'd5;
    for (int k = 0; k < 45; k++) begin
      start = (k < 30);
      tick();
      exp_ready = (k == 9) || (k == 20) || (k == 31);
      checks++;
      if (ready !== exp_ready) begin
        errors++; $display("FAIL b2b_ready cycle %0d got %b want %b", k, ready, exp_ready);
      end
      if (exp_ready) begin
        checks++;
        if (product !== 16'h000F) begin
          errors++; $display("FAIL b2b_product cycle %0d got %h want 000f", k, product);
        end
      end
      if (k == 1 || k == 12 || k == 23) begin
        checks++;
        if (cnt !== 3'd0) begin
          errors++; $display("FAIL b2b_count_after_load cycle %0d got %0d want 0", k, cnt);
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mul(8'd13, 8'd11, 16'h008F, "13x11");
`ifdef SEQ_MUL_SIGNED_EN
    test_mul(8'hFD, 8'h05, 16'hFFF1, "m3x5");
    test_mul(8'h80, 8'h80, 16'h4000, "m128xm128");
    test_mul(8'h7F, 8'hFF, 16'hFF81, "127xm1");
`else
    test_mul(8'hFF, 8'hFF, 16'hFE01, "255x255");
    test_mul(8'h00, 8'hA5, 16'h0000, "0xa5");
    test_mul(8'h01, 8'h80, 16'h0080, "1x80");
`endif
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul_ctrl.md
Name: seq_mul_ctrl

Overview:
- Sequential shift-and-add multiplier controller plus datapath for the ALU.
- Sits directly upstream of the 3-bit iteration counter: drives the counter's ENABLE and synchronous clear, and consumes its count/done outputs.
- Runs exactly 8 add/shift iterations per operation, one per clock.
- Presents a start/ready handshake to the ALU top level.

Parameters:
- WIDTH, 8, operand width in bits. Must equal 2**CNT_W.
- CNT_W, 3, iteration counter width. Must match the counter block.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- a_in  in  WIDTH  multiplicand, latched on an accepted start.
- b_in  in  WIDTH  multiplier, latched on an accepted start.
- iter_count  in  CNT_W  current count from the iteration counter.
- iter_done  in  1  counter terminal flag (count==7).
- cnt_en  out  1  ENABLE to the iteration counter.
- cnt_clr  out  1  synchronous clear to the iteration counter; ORed with RST at the top level.
- busy  out  1  high while an operation is in progress.
- ready  out  1  one-cycle pulse when product is valid.
- product  out  2*WIDTH  result; holds until the next completion.

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE; product=0; ACC=0; Q=0; M=0.
  - busy=0; ready=0; cnt_en=0; cnt_clr=1 while RST is high.
  - Reset mid-operation aborts with no ready pulse.
- FSM states: IDLE, LOAD, ITER, DONE.
  - IDLE: start=1 at an edge -> M<=a_in, Q<=b_in, ACC<=0, carry<=0, go to LOAD. start=0 -> stay.
  - LOAD (1 cycle): cnt_clr=1, busy=1. Next edge: counter reads 0, go to ITER.
  - ITER: cnt_en=1, busy=1. Each edge performs one iteration: {C,ACC} = ACC + (Q[0] ? M : 0), then {C,ACC,Q} >>= 1 (logical).
  - ITER exit: if iter_done=1 at that edge, it is the 8th and final iteration. Go to DONE and latch product <= {shifted ACC, shifted Q}.
  - DONE (1 cycle): ready=1, busy=0, cnt_en=0. Next edge -> IDLE unconditionally.
- Outputs are registered or decoded from state only; there are no combinational paths from input to output.
- Latency: start sampled at edge t -> ready high in the cycle after edge t+9. Throughput: 1 result per 11 cycles with start held high.
- start outside IDLE is ignored; no queueing. A start held high through DONE restarts on the following IDLE edge.
- iter_done/iter_count are ignored outside ITER.
- Consistency check in ITER: iteration index = iter_count. iter_done with iter_count != 7 is a counter fault; sim-only assertion, not acted on in RTL.
- Counter holds at 7 (no wrap), so cnt_clr in LOAD is mandatory before every operation.
- Width rule: product is exact (2*WIDTH bits), with no overflow. a_in/b_in changes after acceptance have no effect.

Optional Feature:
- Macro: SEQ_MUL_SIGNED_EN.
- Defined: radix-2 Booth signed multiply.
  - Extra bit Q_m1 is cleared on load.
  - Each iteration on {Q[0],Q_m1}: 01 -> ACC+=M; 10 -> ACC-=M; else no add.
  - Then arithmetic right shift of {ACC,Q,Q_m1}.
  - product is two's complement.
- Undefined: unsigned shift-add as above; Q_m1 logic absent.
- Handshake and latency are identical in both builds.

Decomposition:
- Package alu_pkg:
  - state enum IDLE/LOAD/ITER/DONE (2-bit encoding 00/01/10/11).
  - constants MUL_WIDTH=8, MUL_CNT_W=3, MUL_ITERS=8.
- One natural sub-module, mul_datapath: M/ACC/Q/carry registers, the adder (full-adder chain), and the shifter, controlled by load/step/latch strobes from the FSM.
- The FSM stays in seq_mul_ctrl.

Test Plan:
- Bench instantiates seq_mul_ctrl with the team's 3-bit iteration counter, cnt_en->ENABLE and cnt_clr|RST->counter reset.
- a=13, b=11, start 1 cycle -> busy for 9 cycles, ready pulse 10 cycles after start, product=0x008F (143).
- a=255, b=255 -> product=0xFE01. a=0, b=0xA5 -> product=0x0000. a=1, b=0x80 -> 0x0080.
- start re-pulsed during ITER with different operands -> ignored; product matches the first operands; exactly one ready pulse.
- RST asserted at the 4th ITER cycle -> next cycle state=IDLE, busy=0, product=0, no ready. A fresh start(6,7) then yields 0x002A.
- start held high for 30 cycles with a=3, b=5 -> ready pulses every 11 cycles, each product=0x000F. Counter reads 0 after each LOAD.
- SEQ_MUL_SIGNED_EN defined:
  - a=-3 (0xFD), b=5 -> product=0xFFF1.
  - a=-128, b=-128 -> 0x4000.
  - a=127, b=-1 -> 0xFF81.
